// File: rtl/mem_arbiter.sv
// Two-port request/ack arbiter in front of a small word-wide data memory.
// Serialises accesses, range/alignment-checks addresses and returns read data with a one-cycle ack.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 64,
    parameter int unsigned ARB_MODE  = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,

    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);
    localparam bit                RR_MODE  = (ARB_MODE != 0);

    state_t state_q, state_d;

    logic gnt_port_q, gnt_port_d;
    logic gnt_we_q, gnt_we_d;
    logic last_grant_q, last_grant_d;

    logic              ack0_d, ack1_d, err0_d, err1_d;
    logic [DATA_W-1:0] rdata0_d, rdata1_d;
    logic [ADDR_W-1:0] mem_address_d;
    logic [DATA_W-1:0] mem_write_data_d;
    logic              mem_write_d, mem_read_d, busy_d;

    logic              elig0, elig1, pick1;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we, sel_legal;
    logic [DATA_W-1:0] cap_data;

    // A request still held during its own ack cycle is not eligible again.
    assign elig0 = req0 && !ack0;
    assign elig1 = req1 && !ack1;

    // Round-robin breaks ties against the last grant; fixed priority always favours port 0.
    assign pick1 = RR_MODE ? (elig1 && (!elig0 || !last_grant_q))
                           : (elig1 && !elig0);

    assign sel_addr  = pick1 ? addr1  : addr0;
    assign sel_we    = pick1 ? we1    : we0;
    assign sel_wdata = pick1 ? wdata1 : wdata0;
    assign sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAX_ADDR);

    assign cap_data  = gnt_we_q ? '0 : mem_read_data;

    // State register plus registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            gnt_port_q     <= 1'b0;
            gnt_we_q       <= 1'b0;
            last_grant_q   <= 1'b1;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            err0           <= 1'b0;
            err1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_port_q     <= gnt_port_d;
            gnt_we_q       <= gnt_we_d;
            last_grant_q   <= last_grant_d;
            ack0           <= ack0_d;
            ack1           <= ack1_d;
            err0           <= err0_d;
            err1           <= err1_d;
            rdata0         <= rdata0_d;
            rdata1         <= rdata1_d;
            mem_address    <= mem_address_d;
            mem_write_data <= mem_write_data_d;
            mem_write      <= mem_write_d;
            mem_read       <= mem_read_d;
            busy           <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d          = state_q;
        gnt_port_d       = gnt_port_q;
        gnt_we_d         = gnt_we_q;
        last_grant_d     = last_grant_q;
        ack0_d           = ack0;
        ack1_d           = ack1;
        err0_d           = err0;
        err1_d           = err1;
        rdata0_d         = rdata0;
        rdata1_d         = rdata1;
        mem_address_d    = mem_address;
        mem_write_data_d = mem_write_data;
        mem_write_d      = mem_write;
        mem_read_d       = mem_read;

        unique case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    gnt_port_d   = pick1;
                    gnt_we_d     = sel_we;
                    last_grant_d = pick1;
                    if (sel_legal) begin
                        state_d          = ISSUE;
                        mem_address_d    = sel_addr;
                        mem_write_data_d = sel_wdata;
                        mem_write_d      = sel_we;
                        mem_read_d       = !sel_we;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            ISSUE: begin
                mem_write_d = 1'b0;
                mem_read_d  = 1'b0;
                state_d     = CAPTURE;
            end
            CAPTURE: begin
                if (gnt_port_q) begin
                    rdata1_d = cap_data;
                    err1_d   = 1'b0;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = cap_data;
                    err0_d   = 1'b0;
                    ack0_d   = 1'b1;
                end
                state_d = DONE;
            end
            ERROR: begin
                if (gnt_port_q) begin
                    rdata1_d = '0;
                    err1_d   = 1'b1;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = '0;
                    err0_d   = 1'b1;
                    ack0_d   = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                err0_d  = 1'b0;
                err1_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_write_d = 1'b0;
                mem_read_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin and one fixed-priority instance share stimulus,
// each backed by its own 16-word memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        preload;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;

    logic        ack0_r, err0_r, ack1_r, err1_r, mem_write_r, mem_read_r, busy_r;
    logic [31:0] rdata0_r, rdata1_r, mem_address_r, mem_write_data_r, mem_read_data_r;
    logic        ack0_f, err0_f, ack1_f, err1_f, mem_write_f, mem_read_f, busy_f;
    logic [31:0] rdata0_f, rdata1_f, mem_address_f, mem_write_data_f, mem_read_data_f;

    logic [31:0] mem_r [16];
    logic [31:0] mem_f [16];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(64), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .ack0(ack0_r), .err0(err0_r), .rdata0(rdata0_r),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .ack1(ack1_r), .err1(err1_r), .rdata1(rdata1_r),
        .mem_address(mem_address_r), .mem_write_data(mem_write_data_r),
        .mem_write(mem_write_r), .mem_read(mem_read_r),
        .mem_read_data(mem_read_data_r), .busy(busy_r)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(64), .ARB_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .ack0(ack0_f), .err0(err0_f), .rdata0(rdata0_f),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .ack1(ack1_f), .err1(err1_f), .rdata1(rdata1_f),
        .mem_address(mem_address_f), .mem_write_data(mem_write_data_f),
        .mem_write(mem_write_f), .mem_read(mem_read_f),
        .mem_read_data(mem_read_data_f), .busy(busy_f)
    );

    // Memory models: word i preloaded with 0x1000_0000 + i; synchronous write, registered read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= 32'h1000_0000 + 32'(i);
                mem_f[i] <= 32'h1000_0000 + 32'(i);
            end
            mem_read_data_r <= '0;
            mem_read_data_f <= '0;
        end else begin
            if (mem_write_r) mem_r[mem_address_r[5:2]] <= mem_write_data_r;
            if (mem_read_r)  mem_read_data_r <= mem_r[mem_address_r[5:2]];
            if (mem_write_f) mem_f[mem_address_f[5:2]] <= mem_write_data_f;
            if (mem_read_f)  mem_read_data_f <= mem_f[mem_address_f[5:2]];
        end
    end

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        preload = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        tests++; if (busy_r !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy_r); end
        tests++; if ({ack0_r, ack1_r, err0_r, err1_r} !== 4'b0) begin fails++; $display("FAIL rst_ack_err got=%b exp=0000", {ack0_r, ack1_r, err0_r, err1_r}); end
        tests++; if ({mem_write_r, mem_read_r} !== 2'b0) begin fails++; $display("FAIL rst_mem_ctl got=%b exp=00", {mem_write_r, mem_read_r}); end
        tests++; if (mem_address_r !== 32'h0) begin fails++; $display("FAIL rst_mem_addr got=%h exp=0", mem_address_r); end
        tests++; if ((rdata0_r | rdata1_r | mem_write_data_r) !== 32'h0) begin fails++; $display("FAIL rst_data got=%h exp=0", rdata0_r | rdata1_r | mem_write_data_r); end
        tests++; if (busy_f !== 1'b0) begin fails++; $display("FAIL rst_busy_fp got=%b exp=0", busy_f); end
        preload = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd8; wdata1 = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++; if ({mem_write_r, mem_read_r} !== 2'b10) begin fails++; $display("FAIL wr_issue_ctl got=%b exp=10", {mem_write_r, mem_read_r}); end
        tests++; if (mem_address_r !== 32'd8) begin fails++; $display("FAIL wr_issue_addr got=%h exp=8", mem_address_r); end
        tests++; if (mem_write_data_r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_issue_data got=%h exp=deadbeef", mem_write_data_r); end
        tests++; if (busy_r !== 1'b1) begin fails++; $display("FAIL wr_busy got=%b exp=1", busy_r); end
        @(negedge clk);
        tests++; if ({mem_write_r, ack1_r} !== 2'b00) begin fails++; $display("FAIL wr_capture got=%b exp=00", {mem_write_r, ack1_r}); end
        @(negedge clk);
        tests++; if ({ack1_r, err1_r} !== 2'b10) begin fails++; $display("FAIL wr_ack got=%b exp=10", {ack1_r, err1_r}); end
        tests++; if (rdata1_r !== 32'h0) begin fails++; $display("FAIL wr_rdata got=%h exp=0", rdata1_r); end
        tests++; if (mem_r[2] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_mem got=%h exp=deadbeef", mem_r[2]); end
        req1 = 1'b0;
        @(negedge clk);
        tests++; if ({ack1_r, busy_r} !== 2'b00) begin fails++; $display("FAIL wr_after got=%b exp=00", {ack1_r, busy_r}); end
        req1 = 1'b1; we1 = 1'b0;
        @(negedge clk);
        tests++; if ({mem_write_r, mem_read_r} !== 2'b01) begin fails++; $display("FAIL rd_issue_ctl got=%b exp=01", {mem_write_r, mem_read_r}); end
        repeat (2) @(negedge clk);
        tests++; if ({ack1_r, err1_r} !== 2'b10) begin fails++; $display("FAIL rd_ack got=%b exp=10", {ack1_r, err1_r}); end
        tests++; if (rdata1_r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_rdata got=%h exp=deadbeef", rdata1_r); end
        tests++; if (rdata1_f !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_rdata_fp got=%h exp=deadbeef", rdata1_f); end
        req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        logic e0r, e1r, e0f, e1f;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd12;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            e0r = (k == 3) || (k == 11);
            e1r = (k == 7) || (k == 15) || (k == 19);
            e0f = (k == 3) || (k == 7) || (k == 11) || (k == 15);
            e1f = (k == 19);
            tests++; if ({ack0_r, ack1_r} !== {e0r, e1r}) begin fails++; $display("FAIL arb_rr k=%0d got=%b exp=%b", k, {ack0_r, ack1_r}, {e0r, e1r}); end
            tests++; if ({ack0_f, ack1_f} !== {e0f, e1f}) begin fails++; $display("FAIL arb_fp k=%0d got=%b exp=%b", k, {ack0_f, ack1_f}, {e0f, e1f}); end
            if (k == 3) begin
                tests++; if (rdata0_r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL arb_rdata0 got=%h exp=deadbeef", rdata0_r); end
            end
            if (k == 7) begin
                tests++; if (rdata1_r !== 32'h1000_0003) begin fails++; $display("FAIL arb_rdata1 got=%h exp=10000003", rdata1_r); end
            end
            if (k == 15) req0 = 1'b0;
            if (k == 19) req1 = 1'b0;
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad[0] = 32'd6;
        bad[1] = 32'd64;
        for (int i = 0; i < 2; i++) begin
            req0 = 1'b1; we0 = 1'b0; addr0 = bad[i];
            @(negedge clk);
            tests++; if ({mem_write_r, mem_read_r, ack0_r, busy_r} !== 4'b0001) begin fails++; $display("FAIL ill_err_state a=%0d got=%b exp=0001", bad[i], {mem_write_r, mem_read_r, ack0_r, busy_r}); end
            @(negedge clk);
            tests++; if ({ack0_r, err0_r, mem_read_r} !== 3'b110) begin fails++; $display("FAIL ill_ack a=%0d got=%b exp=110", bad[i], {ack0_r, err0_r, mem_read_r}); end
            tests++; if (rdata0_r !== 32'h0) begin fails++; $display("FAIL ill_rdata a=%0d got=%h exp=0", bad[i], rdata0_r); end
            tests++; if ({ack0_f, err0_f} !== 2'b11) begin fails++; $display("FAIL ill_ack_fp a=%0d got=%b exp=11", bad[i], {ack0_f, err0_f}); end
            req0 = 1'b0;
            @(negedge clk);
            tests++; if ({ack0_r, err0_r, busy_r} !== 3'b000) begin fails++; $display("FAIL ill_after a=%0d got=%b exp=000", bad[i], {ack0_r, err0_r, busy_r}); end
        end
    endtask

    task automatic test_hold_through_ack();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd12;
        repeat (3) @(negedge clk);
        tests++; if ({ack0_r, rdata0_r} !== {1'b1, 32'h1000_0003}) begin fails++; $display("FAIL hold_ack got=%b/%h exp=1/10000003", ack0_r, rdata0_r); end
        @(negedge clk);
        req0 = 1'b0;
        tests++; if ({ack0_r, busy_r} !== 2'b00) begin fails++; $display("FAIL hold_release got=%b exp=00", {ack0_r, busy_r}); end
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            tests++; if ({busy_r, mem_read_r, ack0_r} !== 3'b000) begin fails++; $display("FAIL hold_dup k=%0d got=%b exp=000", k, {busy_r, mem_read_r, ack0_r}); end
        end
        req0 = 1'b1; addr0 = 32'd8;
        @(negedge clk);
        tests++; if ({mem_read_r, mem_address_r} !== {1'b1, 32'd8}) begin fails++; $display("FAIL hold_reissue got=%b/%h exp=1/8", mem_read_r, mem_address_r); end
        repeat (2) @(negedge clk);
        tests++; if ({ack0_r, rdata0_r} !== {1'b1, 32'hDEAD_BEEF}) begin fails++; $display("FAIL hold_reack got=%b/%h exp=1/deadbeef", ack0_r, rdata0_r); end
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd8;
        repeat (2) @(negedge clk);
        tests++; if (busy_r !== 1'b1) begin fails++; $display("FAIL rmid_busy got=%b exp=1", busy_r); end
        rst_n = 1'b0;
        #1;
        tests++; if ({ack1_r, busy_r, mem_read_r, mem_write_r} !== 4'b0000) begin fails++; $display("FAIL rmid_ctl got=%b exp=0000", {ack1_r, busy_r, mem_read_r, mem_write_r}); end
        tests++; if ({mem_address_r, rdata1_r} !== 64'h0) begin fails++; $display("FAIL rmid_data got=%h/%h exp=0/0", mem_address_r, rdata1_r); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if ({mem_read_r, mem_address_r} !== {1'b1, 32'd8}) begin fails++; $display("FAIL rmid_issue got=%b/%h exp=1/8", mem_read_r, mem_address_r); end
        repeat (2) @(negedge clk);
        tests++; if ({ack1_r, err1_r, rdata1_r} !== {2'b10, 32'hDEAD_BEEF}) begin fails++; $display("FAIL rmid_ack got=%b%b/%h exp=10/deadbeef", ack1_r, err1_r, rdata1_r); end
        req1 = 1'b0;
        @(negedge clk);
        tests++; if ({ack1_r, busy_r} !== 2'b00) begin fails++; $display("FAIL rmid_after got=%b exp=00", {ack1_r, busy_r}); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_arbitration();
        test_illegal();
        test_hold_through_ack();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
